// File: rtl/jtoutrun_obj_pkg.sv
// Shared constants for the OutRun object line buffer: word layout, clear word, shadow nibble.
package jtoutrun_obj_pkg;

    localparam int DW = 14;
    localparam int AW = 9;

    // {pal[6:0], shadow, prio[1:0], pxl[3:0]}
    localparam int PXL_LSB  = 0;
    localparam int PRIO_LSB = 4;
    localparam int SHD_BIT  = 6;
    localparam int PAL_LSB  = 7;

    localparam logic [DW-1:0] OBJ_CLR     = 14'h000F;
    localparam logic [3:0]    OBJ_TRN_PXL = 4'hF;
    localparam logic [3:0]    OBJ_SHD_PXL = 4'hA;

    function automatic logic obj_is_shadow(input logic [DW-1:0] w);
        return w[SHD_BIT] && (w[PXL_LSB +: 4] == OBJ_SHD_PXL);
    endfunction

    // A shadow over a transparent column leaves it transparent.
    function automatic logic [DW-1:0] obj_shade(input logic [DW-1:0] old);
        logic [DW-1:0] w;
        w = old;
        if (old[PXL_LSB +: 4] != OBJ_TRN_PXL) w[SHD_BIT] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/jtoutrun_obj_lbuf_ram.sv
// One line-buffer bank: simple dual-port RAM, one write port, one registered read port.
module jtoutrun_obj_lbuf_ram #(
    parameter int AW = 9,
    parameter int DW = 14
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];

    // Read-before-write on a same-address collision.
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/jtoutrun_obj_lbuf.sv
// Double-buffered object line buffer: draw side fills bank ~sel, mixer reads and clears bank sel.
// Optional shadow read-modify-write merge on the draw side: JTOUTRUN_OBJ_SHADOW_EN.
module jtoutrun_obj_lbuf #(
    parameter int AW = 9,
    parameter int DW = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pxl_cen,
    input  logic          hstart,
    input  logic [DW-1:0] bf_data,
    input  logic          bf_we,
    input  logic [AW-1:0] bf_addr,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] pxl,
    output logic          pxl_ok
);
    import jtoutrun_obj_pkg::*;

    logic          r_sel;
    logic          r_rd_vld;
    logic          r_rd_bank;
    logic [AW-1:0] r_rd_addr;

    logic          w_draw_we;
    logic          w_dbank;
    logic          w_dw_vld;
    logic          w_dw_bank;
    logic [AW-1:0] w_dw_addr;
    logic [DW-1:0] w_dw_wdata;
    logic [DW-1:0] w_rdata [2];

    assign w_draw_we = bf_we & ~hstart;
    assign w_dbank   = ~r_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel     <= 1'b0;
            r_rd_vld  <= 1'b0;
            r_rd_bank <= 1'b0;
            r_rd_addr <= '0;
            pxl       <= OBJ_CLR;
            pxl_ok    <= 1'b0;
        end else begin
            if (hstart) r_sel <= ~r_sel;
            r_rd_vld <= pxl_cen;
            if (pxl_cen) begin
                r_rd_addr <= rd_addr;
                r_rd_bank <= r_sel;
            end
            pxl_ok <= r_rd_vld;
            if (r_rd_vld) pxl <= w_rdata[r_rd_bank];
        end
    end

`ifdef JTOUTRUN_OBJ_SHADOW_EN
    // Every draw write takes two stages so plain writes stay ordered behind merges.
    logic          r_dw_vld;
    logic          r_dw_bank;
    logic          r_dw_shd;
    logic [AW-1:0] r_dw_addr;
    logic [DW-1:0] r_dw_data;
    logic          r_fwd_vld;
    logic [DW-1:0] r_fwd_data;
    logic [DW-1:0] w_dw_old;

    assign w_dw_old   = r_fwd_vld ? r_fwd_data : w_rdata[r_dw_bank];
    assign w_dw_wdata = r_dw_shd ? obj_shade(w_dw_old) : r_dw_data;
    assign w_dw_vld   = r_dw_vld;
    assign w_dw_bank  = r_dw_bank;
    assign w_dw_addr  = r_dw_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dw_vld   <= 1'b0;
            r_dw_bank  <= 1'b0;
            r_dw_shd   <= 1'b0;
            r_dw_addr  <= '0;
            r_dw_data  <= '0;
            r_fwd_vld  <= 1'b0;
            r_fwd_data <= '0;
        end else begin
            r_dw_vld <= w_draw_we;
            if (w_draw_we) begin
                r_dw_bank  <= w_dbank;
                r_dw_shd   <= obj_is_shadow(bf_data);
                r_dw_addr  <= bf_addr;
                r_dw_data  <= bf_data;
                r_fwd_vld  <= r_dw_vld && (r_dw_addr == bf_addr) && (r_dw_bank == w_dbank);
                r_fwd_data <= w_dw_wdata;
            end
        end
    end
`else
    assign w_dw_vld   = w_draw_we;
    assign w_dw_bank  = w_dbank;
    assign w_dw_addr  = bf_addr;
    assign w_dw_wdata = bf_data;
`endif

    for (genvar g = 0; g < 2; g++) begin : g_bank
        localparam logic BID = (g == 1);
        logic          w_we;
        logic [AW-1:0] w_waddr;
        logic [DW-1:0] w_wdata;
        logic [AW-1:0] w_raddr;

        // A clear still in flight just after hstart can meet a draw on the same bank; the clear wins.
        always_comb begin
            w_we    = 1'b0;
            w_waddr = w_dw_addr;
            w_wdata = w_dw_wdata;
            w_raddr = (r_sel == BID) ? rd_addr : bf_addr;
            if (r_rd_vld && (r_rd_bank == BID)) begin
                w_we    = 1'b1;
                w_waddr = r_rd_addr;
                w_wdata = OBJ_CLR;
            end else if (w_dw_vld && (w_dw_bank == BID)) begin
                w_we    = 1'b1;
            end
        end

        jtoutrun_obj_lbuf_ram #(.AW(AW), .DW(DW)) u_ram (
            .i_clk   (clk),
            .i_we    (w_we),
            .i_waddr (w_waddr),
            .i_wdata (w_wdata),
            .i_raddr (w_raddr),
            .o_rdata (w_rdata[g])
        );
    end

endmodule
